// File: rtl/pfb_pkg.sv
// pfb_pkg: shared types and helpers for the PFB coefficient path
//   loader_state_t : coeff_loader FSM states
//   addr_w()       : RAM address width for a given depth
package pfb_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} loader_state_t;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/coeff_loader.sv
// coeff_loader: streams one frame of DEPTH taps from AXI4-Stream into the coefficient RAM write port
//   clk, rst                : clock, async active-high reset
//   start                   : pulse that arms a load (ignored while busy)
//   s_axis_tdata/tvalid/tready/tlast : coefficient stream slave
//   wen, wAddr, din         : registered RAM write port
//   busy                    : loader in LOAD or DRAIN
//   done, err               : sticky result of the last frame (clean / wrong length)
module coeff_loader
   import pfb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WIDTH-1:0]          s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic                      wen,
   output logic [addr_w(DEPTH)-1:0]  wAddr,
   output logic [WIDTH-1:0]          din,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int AW = addr_w(DEPTH);

   loader_state_t state, state_nxt;
   logic [AW-1:0] cnt;
   logic hs, ld_hs, at_end;

   // tready depends on the state register only
   assign s_axis_tready = state != IDLE;
   assign busy          = s_axis_tready;
   assign hs            = s_axis_tready && s_axis_tvalid;
   assign ld_hs         = hs && state == LOAD;
   assign at_end        = cnt == AW'(DEPTH - 1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? LOAD : IDLE;
         LOAD:    state_nxt = !hs ? LOAD : s_axis_tlast ? IDLE : at_end ? DRAIN : LOAD;
         DRAIN:   state_nxt = (hs && s_axis_tlast) ? IDLE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         wen   <= 1'b0;
         wAddr <= '0;
         din   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         wen <= ld_hs;
         if (state == IDLE && start) begin
            cnt  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (ld_hs) begin
            wAddr <= cnt;
            din   <= s_axis_tdata;
            // counter parks on the last address, so a long frame cannot wrap it
            if (!at_end) cnt <= cnt + 1'b1;
            if (s_axis_tlast && at_end) done <= 1'b1;
            // tlast before the last address (short) or missing at it (long)
            if (s_axis_tlast != at_end) err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_coeff_loader.sv
// tb_coeff_loader: scoreboard bench for coeff_loader with a behavioural RAM behind the write port
module tb_coeff_loader;
   import pfb_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 64;
   localparam int AW    = addr_w(DEPTH);

   logic             clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [WIDTH-1:0] tdata = '0;
   logic             tvalid = 1'b0, tlast = 1'b0, tready;
   logic             wen, busy, done, err;
   logic [AW-1:0]    wAddr;
   logic [WIDTH-1:0] din;

   typedef struct {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
      int               due;
   } exp_t;

   exp_t             q[$];
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] img [DEPTH];
   int               checks = 0, failures = 0, cyc = 0;

   coeff_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
      .wen(wen), .wAddr(wAddr), .din(din),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every RAM write must match the head of the scoreboard, one cycle after its handshake
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && wen) begin
         mem[wAddr] = din;
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wAddr, din);
         end else begin
            e = q.pop_front();
            check("write_addr", wAddr, e.addr);
            check("write_data", din, e.data);
            check("write_cycle", cyc, e.due);
         end
      end
   end

   task automatic send_frame(input int n, input int base, input bit gaps, input int start_beat, input int rst_beat);
      int i = 0, idle = 0, s0, bad = 0;
      bit vld, take, tog = 1'b1, aborted = 1'b0;
      start = 1'b1;
      s0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      while (i < n && !aborted) begin
         vld = gaps ? tog : 1'b1;
         tog = !tog;
         tvalid = vld;
         tdata = WIDTH'(base + i);
         tlast = (i == n - 1);
         start = (i == start_beat);
         take = vld && tready;
         @(posedge clk); #1;
         start = 1'b0;
         if (!take) begin
            if (++idle > 200) begin
               checks++;
               failures++;
               $display("FAIL handshake_timeout: got no tready expected beat %0d accepted", i);
               aborted = 1'b1;
            end
         end else if (i == rst_beat) begin
            rst = 1'b1;
            #1;
            check("reset_outputs", {wen, busy, tready, done, err}, 0);
            aborted = 1'b1;
         end else begin
            idle = 0;
            if (i < DEPTH) begin
               q.push_back('{AW'(i), WIDTH'(base + i), cyc});
               img[i] = WIDTH'(base + i);
            end
            if (n > DEPTH && i == DEPTH - 1) check("long_err_with_last_write", {err, busy, wen}, 3'b111);
            if (n > DEPTH && i == n - 2)     check("drain_busy", busy, 1);
            if (n <= DEPTH && i == n - 2)    check("no_status_before_end", {done, err}, 0);
            i++;
         end
      end
      tvalid = 1'b0;
      tlast = 1'b0;
      if (!aborted) begin
         check("status", {done, err, busy, tready}, {n == DEPTH, n != DEPTH, 2'b00});
         if (!gaps && n == DEPTH && start_beat < 0) check("done_cycle", cyc - s0, DEPTH + 1);
      end
      repeat (3) @(posedge clk);
      #1;
      if (rst) begin
         check("reset_hold", {wen, busy, tready, done, err}, 0);
         rst = 1'b0;
      end
      check("all_writes_seen", q.size(), 0);
      q.delete();
      foreach (img[k]) if (mem[k] !== img[k]) bad++;
      check("ram_image", bad, 0);
   endtask

   initial begin
      foreach (mem[k]) begin
         mem[k] = WIDTH'(16'hC000 + k);
         img[k] = mem[k];
      end
      #1 rst = 1'b1;
      #2 check("reset_state", {wen, busy, tready, done, err, 16'(wAddr), din}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      send_frame(64, 'h1000, 1'b0, -1, -1);
      send_frame(64, 'h2000, 1'b1, -1, -1);
      send_frame(11, 'h3000, 1'b0, -1, -1);
      send_frame(70, 'h4000, 1'b0, -1, -1);
      send_frame(64, 'h5000, 1'b0, -1, 20);
      send_frame(64, 'h6000, 1'b0, -1, -1);
      send_frame(64, 'h7000, 1'b0, 5, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
